// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform core: mode encoding and the
// elaboration-time quarter-wave sine table generator.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SAW = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SQR = 2'd2,
    MODE_SIN = 2'd3
  } mode_e;

  localparam int unsigned FRAC_W = 30;
  // pi in Q30 fixed point
  localparam longint      PI_Q30 = 64'sd3373259426;

  // round((2^(data_w-1)-1) * sin(pi*(2k+1)/2^phase_w)) using a Q30 Taylor series
  function automatic int unsigned sine_q(int unsigned k, int unsigned phase_w,
                                         int unsigned data_w);
    longint theta;
    longint term;
    longint sum;
    longint amp;
    longint q;
    theta = (PI_Q30 * longint'(2 * k + 1)) >>> phase_w;
    term  = theta;
    sum   = theta;
    for (int n = 1; n <= 7; n++) begin
      term = (term * theta) >>> FRAC_W;
      term = (term * theta) >>> FRAC_W;
      term = -(term / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (data_w - 1)) - 1;
    q   = (amp * sum + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
    if (q < 0)   q = 0;
    if (q > amp) q = amp;
    return 32'(q);
  endfunction

endpackage

// File: rtl/dds_wave_core_if.sv
// Control and sample bus between the register logic and the DDS core.
interface dds_wave_core_if #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned DATA_W  = 8
);
  logic               ce;
  logic               oce;
  logic [ACC_W-1:0]   ftw_in;
  logic               ftw_wr;
  logic [1:0]         mode_in;
  logic               mode_wr;
  logic [PHASE_W-1:0] duty_in;
  logic               sync_clr;
  logic [DATA_W-1:0]  dout;
  logic               dout_valid;
  logic               wrap;
  logic [1:0]         mode_active;

  modport master (
    output ce, oce, ftw_in, ftw_wr, mode_in, mode_wr, duty_in, sync_clr,
    input  dout, dout_valid, wrap, mode_active
  );

  modport slave (
    input  ce, oce, ftw_in, ftw_wr, mode_in, mode_wr, duty_in, sync_clr,
    output dout, dout_valid, wrap, mode_active
  );
endinterface

// File: rtl/sine_quarter_rom.sv
// Synchronous-read quarter-wave sine magnitude ROM (no reset, block-ROM style).
module sine_quarter_rom
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                clk,
  input  logic                ce,
  input  logic [PHASE_W-3:0]  addr,
  output logic [DATA_W-2:0]   q
);
  localparam int unsigned DEPTH = 2 ** (PHASE_W - 2);

  logic [DATA_W-2:0] w_rom [DEPTH];
  logic [DATA_W-2:0] r_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign w_rom[k] = (DATA_W-1)'(sine_q(32'(k), PHASE_W, DATA_W));
  end

  always_ff @(posedge clk) begin
    if (ce) r_q <= w_rom[addr];
  end

  assign q = r_q;
endmodule

// File: rtl/dds_wave_core.sv
// DDS core: phase accumulator, mode-switch-at-wrap control and a three-stage
// waveform pipeline (acc -> waveform/ROM -> output register).
module dds_wave_core
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  dds_wave_core_if.slave   bus
);
  localparam int unsigned TRI_W  = PHASE_W - 1;
  localparam int unsigned ADDR_W = PHASE_W - 2;

  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_ftw;
  logic               r_carry;
  mode_e              r_mode_active;
  mode_e              r_mode_pend;
  logic               r_pend;

  logic [DATA_W-1:0]  r_s1_wave;
  mode_e              r_s1_mode;
  logic               r_s1_neg;
  logic               r_s1_carry;
  logic               r_v1;

  logic [DATA_W-1:0]  r_dout;
  logic               r_wrap;
  logic               r_valid;

  logic [ACC_W:0]     w_sum;
  logic               w_carry_set;
  logic               w_apply;
  logic [PHASE_W-1:0] w_p;
  logic [TRI_W-1:0]   w_tri_p;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_saw;
  logic [DATA_W-1:0]  w_tri;
  logic [DATA_W-1:0]  w_sqr;
  logic [DATA_W-1:0]  w_wave;
  logic [DATA_W-2:0]  w_rom_q;
  logic [DATA_W-1:0]  w_sin;
  logic [DATA_W-1:0]  w_s2;

  assign w_sum       = {1'b0, r_acc} + {1'b0, r_ftw};
  assign w_carry_set = bus.ce & (bus.sync_clr | w_sum[ACC_W]);
  // A parked mode only lands on a period boundary, or at once when the phase is static
  assign w_apply     = r_pend & (w_carry_set | (r_ftw == '0));

  assign w_p     = r_acc[ACC_W-1 -: PHASE_W];
  assign w_tri_p = w_p[PHASE_W-1] ? ~w_p[TRI_W-1:0] : w_p[TRI_W-1:0];
  assign w_addr  = w_p[PHASE_W-2] ? ~w_p[ADDR_W-1:0] : w_p[ADDR_W-1:0];
  assign w_sqr   = (w_p < bus.duty_in) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

  if (PHASE_W >= DATA_W) begin : g_saw_trunc
    assign w_saw = w_p[PHASE_W-1 -: DATA_W];
  end else begin : g_saw_pad
    assign w_saw = {w_p, {(DATA_W-PHASE_W){1'b0}}};
  end

  if (TRI_W >= DATA_W) begin : g_tri_trunc
    assign w_tri = w_tri_p[TRI_W-1 -: DATA_W];
  end else begin : g_tri_pad
    assign w_tri = {w_tri_p, {(DATA_W-TRI_W){1'b0}}};
  end

  always_comb begin
    w_wave = w_saw;
    unique case (r_mode_active)
      MODE_TRI: w_wave = w_tri;
      MODE_SQR: w_wave = w_sqr;
      default:  w_wave = w_saw;
    endcase
  end

  // Offset-binary sine: upper half adds the magnitude, lower half mirrors it below mid-scale
  assign w_sin = r_s1_neg ? {1'b0, ~w_rom_q} : {1'b1, w_rom_q};
  assign w_s2  = (r_s1_mode == MODE_SIN) ? w_sin : r_s1_wave;

  sine_quarter_rom #(
    .PHASE_W (PHASE_W),
    .DATA_W  (DATA_W)
  ) u_rom (
    .clk  (clk),
    .ce   (bus.ce),
    .addr (w_addr),
    .q    (w_rom_q)
  );

  // Tuning word and mode bookkeeping run regardless of ce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ftw         <= '0;
      r_mode_active <= MODE_SAW;
      r_mode_pend   <= MODE_SAW;
      r_pend        <= 1'b0;
    end else begin
      if (bus.ftw_wr) r_ftw <= bus.ftw_in;
      if (bus.mode_wr) begin
        r_mode_pend <= mode_e'(bus.mode_in);
        r_pend      <= 1'b1;
      end else if (w_apply) begin
        r_mode_active <= r_mode_pend;
        r_pend        <= 1'b0;
      end
    end
  end

  // Stage 0 and stage 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_s1_wave  <= '0;
      r_s1_mode  <= MODE_SAW;
      r_s1_neg   <= 1'b0;
      r_s1_carry <= 1'b0;
      r_v1       <= 1'b0;
    end else if (bus.ce) begin
      r_s1_wave  <= w_wave;
      r_s1_mode  <= r_mode_active;
      r_s1_neg   <= w_p[PHASE_W-1];
      r_s1_carry <= r_carry;
      r_v1       <= 1'b1;
      if (bus.sync_clr) begin
        r_acc   <= '0;
        r_carry <= 1'b1;
      end else begin
        r_acc   <= w_sum[ACC_W-1:0];
        r_carry <= w_sum[ACC_W];
      end
    end
  end

  // Stage 2 output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout  <= '0;
      r_wrap  <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.oce) begin
      r_dout <= w_s2;
      r_wrap <= r_s1_carry;
      if (bus.ce && r_v1) r_valid <= 1'b1;
    end
  end

  assign bus.dout        = r_dout;
  assign bus.wrap        = r_wrap;
  assign bus.dout_valid  = r_valid;
  assign bus.mode_active = r_mode_active;
endmodule

// File: doc/dds_wave_core.md
# dds_wave_core

Parametrised DDS waveform core: a phase accumulator driven by a programmable frequency tuning word, followed by a multi-mode waveform stage (sawtooth, triangle, square with programmable duty, quarter-wave sine). It is the successor to the fixed 64-entry sawtooth lookup. It sits between the control/register logic and the DAC output path, and produces one unsigned offset-binary sample per enabled clock.

## Interface
Parameters:
- ACC_W, 32: phase accumulator width.
- PHASE_W, 8: phase bits taken from the accumulator MSBs; must be ≥ 4.
- DATA_W, 8: output sample width; must be ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sample clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable for accumulator, pipeline and sine ROM.
- oce  in  1  output-register enable.
- ftw_in  in  ACC_W  frequency tuning word.
- ftw_wr  in  1  load strobe for ftw_in.
- mode_in  in  2  waveform select: 0 saw, 1 triangle, 2 square, 3 sine.
- mode_wr  in  1  load strobe for mode_in; the new mode becomes pending.
- duty_in  in  PHASE_W  square threshold; sampled every cycle.
- sync_clr  in  1  phase reset.
- dout  out  DATA_W  sample.
- dout_valid  out  1  pipeline filled.
- wrap  out  1  one-sample pulse marking the first sample after a phase overflow.
- mode_active  out  2  mode currently generating.

## Operation
- Registers ftw, mode_active and mode_pend reset to 0. The accumulator acc resets to 0. All outputs reset to 0.
- ftw_wr loads ftw_in at the next edge, independent of ce. The new word is used from the following enabled edge.
- Accumulator, on each edge with ce=1:
  - sync_clr=1: acc←0 and carry←1.
  - otherwise: acc←(acc+ftw) mod 2^ACC_W, and carry←the adder carry-out.
- mode_wr sets mode_pend←mode_in and a pending flag, independent of ce. The pending mode is applied on the same edge that sets carry=1, or immediately on the next edge if ftw==0. A mode_wr in that same cycle wins, and its value stays pending. mode_active therefore never changes mid-period.
- Phase p = acc[ACC_W-1 -: PHASE_W]. "Left-align to DATA_W" means zero-pad the LSBs, or truncate LSBs if the source is wider.
- Waveforms:
  - saw = p, left-aligned.
  - tri = p[MSB] ? ~p[PHASE_W-2:0] : p[PHASE_W-2:0], left-aligned.
  - square = (p < duty_in) ? all-ones : 0.
  - sine: addr = p[PHASE_W-2] ? ~p[PHASE_W-3:0] : p[PHASE_W-3:0]. Output is 2^(DATA_W-1)+q[addr] when p[MSB]=0, else 2^(DATA_W-1)-1-q[addr].
  - Sine table: q[k] = round((2^(DATA_W-1)-1)·sin(π/2·(k+0.5)/2^(PHASE_W-2))), with k = 0 … 2^(PHASE_W-2)-1.
- ce=0: acc, carry, stage 1, the ROM and the fill flag all hold. oce=0: dout, wrap and dout_valid hold while stage 1 still advances under ce.
- dout_valid: v1 sets on the first ce edge after reset. dout_valid sets on the first ce&oce edge with v1=1. Both stay set until reset.
- Reset asserted mid-operation clears everything asynchronously, including the pending mode and ftw. There is no partial state.

## Timing
- Stage 0 is acc/carry. Stage 1 is the waveform register plus the sine ROM's synchronous read, registering sample(acc) and carry. Stage 2 is the output register (dout, wrap).
- Latency: the acc value present after edge n appears on dout after edge n+2, assuming ce=oce=1.
- wrap is aligned with the dout sample computed from the post-overflow acc.
- A mode change applies at the overflow edge, so the first sample in the new mode is exactly the one flagged by wrap.
- Throughput is one sample per ce cycle. There is no backpressure.

## Structure
- Shared package dds_pkg holds the mode encoding constants (MODE_SAW, MODE_TRI, MODE_SQR, MODE_SIN) and the sine-table generation function (integer rounding, evaluated at elaboration).
- Sub-module sine_quarter_rom is a 2^(PHASE_W-2)×(DATA_W-1) synchronous-read ROM. It has ports clk, ce, addr and q, has no reset, and maps to block ROM.
- Everything else lives in dds_wave_core.

## Test plan
Defaults throughout: ACC_W=32, PHASE_W=8, DATA_W=8.
- Saw ramp: reset, ce=oce=1, ftw_wr with 0x0100_0000, mode 0. Required: dout runs 0…255 in steps of 1. wrap=1 exactly on each dout=0 after 255. dout_valid=1 from the second edge after reset.
- Sine extrema: mode 3, same ftw. Required: p=0→130, p=64→255, p=192→0, p=128→125. The sequence repeats every 256 samples.
- Triangle and square: mode 1 gives p=0→0, 127→254, 128→254, 255→0. Mode 2 with duty_in=0x40 gives 255 for p<64, else 0.
- Mode switch at wrap: run saw, then pulse mode_wr=3 at p≈100. Required: saw continues to 255, and the sample flagged by wrap is 130 (sine). With ftw=0, mode_wr applies on the next edge.
- ce/oce gating: hold ce=0 for 5 cycles mid-ramp, then resume. Required: dout is frozen and resumes with the next consecutive value, with no skipped value. With oce=0, dout holds, and after oce returns dout jumps to the current stage-1 value.
- sync_clr and async reset: sync_clr at p=77 makes dout show 0 with wrap=1 two edges later. reset_n asserted mid-ramp forces dout, wrap, dout_valid and mode_active to 0 immediately, without waiting for a clock edge.
